// File: rtl/cpl_dw_packer.sv
// Packs tagged 32-bit completion payload DWs into 128-bit words per tag for the gather read DMA.
// Build option: define PACKER_BYTE_SWAP_EN to byte-reverse every incoming DW before packing.
module cpl_dw_packer #(
  parameter int unsigned P_TAG_BITS = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         cpl_valid,
  input  logic [7:0]   cpl_tag,
  input  logic [31:0]  cpl_data,
  input  logic         cpl_eop,
  input  logic         cpl_last,
  output logic [7:0]   packer_tag,
  output logic [127:0] packer_dout,
  output logic [3:0]   packer_dout_dwen,
  output logic         packer_valid,
  output logic         packer_done,
  output logic         err_tag
);

  localparam int unsigned P_TAGS = 2 ** P_TAG_BITS;

  logic [1:0]            cnt_q  [P_TAGS];
  logic [95:0]           hold_q [P_TAGS];

  logic [7:0]            tag_q;
  logic [127:0]          dout_q;
  logic [3:0]            dwen_q;
  logic                  valid_q;
  logic                  done_q;
  logic                  err_q;

  logic [7:0]            tag_hi;
  logic                  in_range;
  logic [P_TAG_BITS-1:0] tag_idx;
  logic [31:0]           din;
  logic                  beat;
  logic                  req_end;
  logic                  emit;
  logic [1:0]            n;
  logic [95:0]           hold_cur;
  logic [127:0]          word_d;
  logic [3:0]            dwen_d;

`ifdef PACKER_BYTE_SWAP_EN
  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
  assign din = swap_bytes(cpl_data);
`else
  assign din = cpl_data;
`endif

  assign tag_hi   = cpl_tag >> P_TAG_BITS;
  assign in_range = (tag_hi == 8'd0);
  assign tag_idx  = cpl_tag[P_TAG_BITS-1:0];

  // A flush in the same cycle wins over the beat, which is dropped.
  assign beat     = cpl_valid && in_range && !i_flush;
  assign n        = cnt_q[tag_idx];
  assign hold_cur = hold_q[tag_idx];
  assign req_end  = cpl_eop && cpl_last;
  assign emit     = beat && ((n == 2'd3) || req_end);

  always_comb begin
    word_d = '0;
    dwen_d = '0;
    unique case (n)
      2'd0: begin
        word_d = {96'd0, din};
        dwen_d = 4'b0001;
      end
      2'd1: begin
        word_d = {64'd0, din, hold_cur[31:0]};
        dwen_d = 4'b0011;
      end
      2'd2: begin
        word_d = {32'd0, din, hold_cur[63:0]};
        dwen_d = 4'b0111;
      end
      default: begin
        word_d = {din, hold_cur};
        dwen_d = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < P_TAGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (i_flush) begin
      for (int unsigned i = 0; i < P_TAGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (beat) begin
      cnt_q[tag_idx] <= emit ? 2'd0 : n + 2'd1;
    end
  end

  // Payload storage needs no reset: lanes are only read below the tag's count.
  always_ff @(posedge i_clk) begin
    if (beat && !emit) begin
      unique case (n)
        2'd0:    hold_q[tag_idx][31:0]  <= din;
        2'd1:    hold_q[tag_idx][63:32] <= din;
        default: hold_q[tag_idx][95:64] <= din;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_q   <= '0;
      dout_q  <= '0;
      dwen_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= emit;
      done_q  <= emit && req_end;
      if (emit) begin
        tag_q  <= cpl_tag;
        dout_q <= word_d;
        dwen_q <= dwen_d;
      end
      if (cpl_valid && !in_range) begin
        err_q <= 1'b1;
      end
    end
  end

  assign packer_tag       = tag_q;
  assign packer_dout      = dout_q;
  assign packer_dout_dwen = dwen_q;
  assign packer_valid     = valid_q;
  assign packer_done      = done_q;
  assign err_tag          = err_q;

endmodule
